// File: rtl/product_accumulation_pkg.sv
// Shared helpers for the convolution product/accumulation stages.
// Latency: n/a (constant functions and a pure saturating clamp).
// Backpressure: n/a.
package product_accumulation_pkg;

  // Ceiling log2; returns 0 for value <= 1 so a single-element tree has no levels.
  function automatic int clog2_fn(input int value);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width: product width plus one bit per tree level plus headroom for the bias add.
  function automatic int acc_width_fn(input int pw, input int n);
    return pw + clog2_fn(n) + 1;
  endfunction

  // Flat-bus element index for filter n, channel k, row j, column i.
  function automatic int flat_idx(input int n, input int k, input int j, input int i,
                                  input int w, input int h, input int d);
    return n * w * h * d + k * w * h + j * w + i;
  endfunction

  // Clamp a signed value into the range of a signed word of the given width.
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] value, input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/product_accumulation_adder_tree_pipe.sv
// One filter's pipelined adder tree: N signed products -> ACC_W sum, bias carried alongside.
// Latency: LEVELS cycles (combinational pass-through when N = 1).
// Backpressure: every register holds while en_i is low.
module product_accumulation_adder_tree_pipe
  import product_accumulation_pkg::*;
#(
  parameter int N             = 27,
  parameter int PRODUCT_WIDTH = 16,
  parameter int BIAS_WIDTH    = 16,
  parameter int ACC_W         = 22,
  parameter int LEVELS        = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [N*PRODUCT_WIDTH-1:0]    products_i,
  input  logic [BIAS_WIDTH-1:0]         bias_i,
  output logic signed [ACC_W-1:0]       sum_o,
  output logic signed [ACC_W-1:0]       bias_o
);

  // Each level is kept 2*N wide so pair (2j, 2j+1) is always in range; entries past the
  // live count stay zero, which makes an odd tail pass through paired with zero.
  localparam int NP = 2 * N;

  logic signed [ACC_W-1:0] leaf [NP];
  logic signed [ACC_W-1:0] bias_ext;

  assign bias_ext = ACC_W'($signed(bias_i));

  // Sign-extend every product to the accumulator width; padding slots are zero.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      leaf[k] = '0;
    end
    for (int k = 0; k < N; k++) begin
      leaf[k] = ACC_W'($signed(products_i[k*PRODUCT_WIDTH +: PRODUCT_WIDTH]));
    end
  end

  if (LEVELS == 0) begin : g_flat
    assign sum_o  = leaf[0];
    assign bias_o = bias_ext;
  end else begin : g_tree
    logic signed [ACC_W-1:0] node_q [LEVELS][NP];
    logic signed [ACC_W-1:0] bias_q [LEVELS];

    // Pairwise-sum each level into the next and shift the bias down its delay line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int l = 0; l < LEVELS; l++) begin
          bias_q[l] <= '0;
          for (int j = 0; j < NP; j++) begin
            node_q[l][j] <= '0;
          end
        end
      end else if (en_i) begin
        for (int j = 0; j < N; j++) begin
          node_q[0][j] <= leaf[2*j] + leaf[2*j+1];
        end
        for (int l = 1; l < LEVELS; l++) begin
          for (int j = 0; j < N; j++) begin
            node_q[l][j] <= node_q[l-1][2*j] + node_q[l-1][2*j+1];
          end
        end
        bias_q[0] <= bias_ext;
        for (int l = 1; l < LEVELS; l++) begin
          bias_q[l] <= bias_q[l-1];
        end
      end
    end

    assign sum_o  = node_q[LEVELS-1][0];
    assign bias_o = bias_q[LEVELS-1];
  end

endmodule

// File: rtl/product_accumulation.sv
// Reduces each filter's products to one sum, adds bias, arithmetic-shifts and saturates.
// Latency: LEVELS+1 cycles from acceptance to out_valid (6 for the default 3x3x3 window).
// Backpressure: whole pipeline advances only when !out_valid | out_ready; in_ready mirrors that.
module product_accumulation
  import product_accumulation_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int HEIGHT        = 3,
  parameter int DEPTH         = 3,
  parameter int NUM_FILTER    = 3,
  parameter int PRODUCT_WIDTH = 16,
  parameter int BIAS_WIDTH    = 16,
  parameter int SUM_WIDTH     = 16,
  parameter int SHIFT         = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [PRODUCT_WIDTH*WIDTH*HEIGHT*DEPTH*NUM_FILTER-1:0] products,
  input  logic [BIAS_WIDTH*NUM_FILTER-1:0]                       bias,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [SUM_WIDTH*NUM_FILTER-1:0]                        sums
);

  localparam int N      = WIDTH * HEIGHT * DEPTH;
  localparam int LEVELS = clog2_fn(N);
  localparam int ACC_W  = acc_width_fn(PRODUCT_WIDTH, N);

  logic                              advance;
  logic [LEVELS:0]                   vld_q;
  logic [LEVELS:0]                   vld_d;
  logic [SUM_WIDTH*NUM_FILTER-1:0]   sums_q;
  logic [SUM_WIDTH*NUM_FILTER-1:0]   sums_d;
  logic signed [ACC_W-1:0]           tree_sum  [NUM_FILTER];
  logic signed [ACC_W-1:0]           tree_bias [NUM_FILTER];
  logic signed [ACC_W:0]             biased    [NUM_FILTER];
  logic signed [ACC_W:0]             shifted   [NUM_FILTER];

  // vld_q[LEVELS] is the output register's valid; lower bits track the tree levels.
  assign out_valid = vld_q[LEVELS];
  assign advance   = !vld_q[LEVELS] || out_ready;
  assign in_ready  = advance;
  assign sums      = sums_q;

  for (genvar n = 0; n < NUM_FILTER; n++) begin : g_filter
    localparam int BASE = flat_idx(n, 0, 0, 0, WIDTH, HEIGHT, DEPTH) * PRODUCT_WIDTH;

    product_accumulation_adder_tree_pipe #(
      .N             (N),
      .PRODUCT_WIDTH (PRODUCT_WIDTH),
      .BIAS_WIDTH    (BIAS_WIDTH),
      .ACC_W         (ACC_W),
      .LEVELS        (LEVELS)
    ) u_tree (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (advance),
      .products_i (products[BASE +: N*PRODUCT_WIDTH]),
      .bias_i     (bias[n*BIAS_WIDTH +: BIAS_WIDTH]),
      .sum_o      (tree_sum[n]),
      .bias_o     (tree_bias[n])
    );
  end

  // Valid bits shift one slot per advance; slot 0 takes the incoming beat's valid.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int i = 1; i <= LEVELS; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Bias add one bit wider than the tree, then floor shift and clamp to the output word.
  always_comb begin
    sums_d = '0;
    for (int n = 0; n < NUM_FILTER; n++) begin
      biased[n]  = (ACC_W+1)'(tree_sum[n]) + (ACC_W+1)'(tree_bias[n]);
      shifted[n] = biased[n] >>> SHIFT;
      sums_d[n*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(sat_fn(64'(shifted[n]), SUM_WIDTH));
    end
  end

  // Valid chain and output register move together; sums only load for a valid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sums_q <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      if (vld_d[LEVELS]) begin
        sums_q <= sums_d;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulation.sv
// Bench for product_accumulation: table vectors, hand sequences and a randomized scoreboard.
// Two instances (SHIFT=0 and SHIFT=2) share all inputs.
// Outputs sampled on the falling edge; inputs driven 1ns after the rising edge.
module tb_product_accumulation;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int D  = 3;
  localparam int NF = 3;
  localparam int PW = 16;
  localparam int BW = 16;
  localparam int SW = 16;
  localparam int N  = W * H * D;
  localparam int PB = PW * N * NF;
  localparam int BB = BW * NF;
  localparam int SB = SW * NF;
  localparam int NT = 7;

  typedef struct packed {
    logic [15:0]      prod;
    logic [2:0][15:0] b;
    logic [2:0][15:0] e0;
    logic [2:0][15:0] e2;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PB-1:0] products = '0;
  logic [BB-1:0] bias = '0;
  logic          in_ready0, in_ready2, out_valid0, out_valid2;
  logic [SB-1:0] sums0, sums2;

  int            n_vec = 0;
  int            n_err = 0;
  logic [SB-1:0] q0 [$];
  logic [SB-1:0] q2 [$];
  int            out_cnt = 0;
  logic          stall0 = 1'b0, stall2 = 1'b0;
  logic [SB-1:0] held0 = '0, held2 = '0;
  logic          chk_rdy = 1'b0;
  logic          last_acc = 1'b0;
  vec_t          tbl [NT];

  always #5 clk = ~clk;

  product_accumulation #(.SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .products(products), .bias(bias), .out_valid(out_valid0),
    .out_ready(out_ready), .sums(sums0));

  product_accumulation #(.SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .products(products), .bias(bias), .out_valid(out_valid2),
    .out_ready(out_ready), .sums(sums2));

  task automatic check(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum all products of a filter, add bias, floor-divide by 2^sh, clamp.
  function automatic logic [SB-1:0] model(input logic [PB-1:0] p, input logic [BB-1:0] b, input int sh);
    logic [SB-1:0] r;
    longint acc;
    r = '0;
    for (int n = 0; n < NF; n++) begin
      acc = 0;
      for (int e = 0; e < N; e++) acc += longint'($signed(p[(n*N+e)*PW +: PW]));
      acc += longint'($signed(b[n*BW +: BW]));
      acc = acc >>> sh;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      r[n*SW +: SW] = acc[SW-1:0];
    end
    return r;
  endfunction

  function automatic vec_t mk(input int p, input int b0, input int b1, input int b2,
                              input int e00, input int e01, input int e02,
                              input int e20, input int e21, input int e22);
    vec_t v;
    v.prod  = 16'(p);
    v.b[0]  = 16'(b0);  v.b[1]  = 16'(b1);  v.b[2]  = 16'(b2);
    v.e0[0] = 16'(e00); v.e0[1] = 16'(e01); v.e0[2] = 16'(e02);
    v.e2[0] = 16'(e20); v.e2[1] = 16'(e21); v.e2[2] = 16'(e22);
    return v;
  endfunction

  task automatic set_uniform(input logic [15:0] p, input logic [2:0][15:0] b);
    for (int e = 0; e < N * NF; e++) products[e*PW +: PW] = p;
    for (int n = 0; n < NF; n++) bias[n*BW +: BW] = b[n];
  endtask

  task automatic rand_beat();
    int mode;
    int v;
    mode = int'($urandom_range(0, 2));
    for (int e = 0; e < N * NF; e++) begin
      if (mode == 0) v = int'($urandom_range(0, 65535));
      else if (mode == 1) v = int'($urandom_range(0, 400)) - 200;
      else v = int'($urandom_range(0, 3000));
      products[e*PW +: PW] = 16'(v);
    end
    for (int n = 0; n < NF; n++) bias[n*BW +: BW] = 16'($urandom);
  endtask

  // Scoreboard sampling point; called once per cycle on the falling edge.
  task automatic mon_sample();
    if (!rst_n) begin
      q0.delete();
      q2.delete();
      stall0 = 1'b0;
      stall2 = 1'b0;
      last_acc = 1'b0;
      return;
    end
    if (stall0) begin
      check_i("stall_vld0", int'(out_valid0), 1);
      check("stall_sums0", sums0, held0);
    end
    if (stall2) begin
      check_i("stall_vld2", int'(out_valid2), 1);
      check("stall_sums2", sums2, held2);
    end
    if (chk_rdy) check_i("in_ready", int'(in_ready0), int'(!(out_valid0 && !out_ready)));
    if (in_valid && in_ready0) q0.push_back(model(products, bias, 0));
    if (in_valid && in_ready2) q2.push_back(model(products, bias, 2));
    last_acc = in_valid && in_ready0;
    if (out_valid0 && out_ready) begin
      out_cnt++;
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_out0: got %h expected no output", sums0);
      end else check("result0", sums0, q0.pop_front());
    end
    if (out_valid2 && out_ready) begin
      out_cnt++;
      if (q2.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_out2: got %h expected no output", sums2);
      end else check("result2", sums2, q2.pop_front());
    end
    stall0 = out_valid0 && !out_ready;
    stall2 = out_valid2 && !out_ready;
    held0  = sums0;
    held2  = sums2;
  endtask

  task automatic tick();
    @(negedge clk);
    mon_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q0.size() > 0 || q2.size() > 0) && g < 100) begin
      tick();
      g++;
    end
    check_i("drain_empty", q0.size() + q2.size(), 0);
  endtask

  initial begin
    int lat;
    int seen;
    int idx;
    int c;
    int base;

    tbl[0] = mk(1, 0, 5, -5, 27, 32, 22, 6, 8, 5);
    tbl[1] = mk(32767, 0, 0, 0, 32767, 32767, 32767, 32767, 32767, 32767);
    tbl[2] = mk(-32768, 0, 0, 0, -32768, -32768, -32768, -32768, -32768, -32768);
    tbl[3] = mk(4, -8, -8, -8, 100, 100, 100, 25, 25, 25);
    tbl[4] = mk(-1, 0, 0, 0, -27, -27, -27, -7, -7, -7);
    tbl[5] = mk(1000, 100, -100, 0, 27100, 26900, 27000, 6775, 6725, 6750);
    tbl[6] = mk(-2000, 0, 30000, -30000, -32768, -24000, -32768, -13500, -6000, -21000);

    // Reset held with in_valid high.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rand_beat();
    repeat (3) tick();
    check_i("rst_vld0", int'(out_valid0), 0);
    check_i("rst_vld2", int'(out_valid2), 0);
    check("rst_sums0", sums0, '0);
    check("rst_sums2", sums2, '0);
    rst_n = 1'b1; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid0 || out_valid2) seen++;
    end
    check_i("idle_after_reset", seen, 0);

    // Table vectors: single beat each, latency, values, one-cycle valid.
    for (int t = 0; t < NT; t++) begin
      set_uniform(tbl[t].prod, tbl[t].b);
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid0 && lat < 40) begin
        tick();
        lat++;
      end
      check_i("latency", lat, 6);
      check("tbl_sums0", sums0, tbl[t].e0);
      check("tbl_sums2", sums2, tbl[t].e2);
      tick();
      check_i("one_cycle_valid", int'(out_valid0), 0);
    end

    // Back-pressure: 10 beats of value idx with out_ready 1,0,0 repeating.
    chk_rdy = 1'b1;
    base = out_cnt;
    idx = 0;
    c = 0;
    while (idx < 10 && c < 300) begin
      in_valid = 1'b1;
      set_uniform(16'(idx), '0);
      out_ready = (c % 3 == 0);
      tick();
      if (last_acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    while ((q0.size() > 0 || q2.size() > 0) && c < 400) begin
      out_ready = (c % 3 == 0);
      tick();
      c++;
    end
    check_i("bp_count", out_cnt - base, 20);
    drain();

    // Reset mid-flight: three beats in, reset, nothing may emerge.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      set_uniform(16'(k + 5), '0);
      tick();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid0 || out_valid2) seen++;
    end
    check_i("no_out_after_midreset", seen, 0);
    base = out_cnt;
    in_valid = 1'b1;
    rand_beat();
    tick();
    drain();
    check_i("first_after_midreset", out_cnt - base, 2);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_beat();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
